// File: rtl/hold_slice.sv
// hold_slice: single-clock valid/ready register slice with a two-entry skid
// buffer. Both handshake directions are registered:
//   - in_ready depends only on the slice state, never on out_ready.
//   - out_valid and out_data come straight from flops.
// While out_valid is high and out_ready is low, out_data is held stable.
// A saturating counter tracks the stall cycles (out_valid && !out_ready).
//
// Parameters: WIDTH (data bits), CNT_W (stall counter bits)
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     upstream handshake
//   in_data               upstream data
//   out_valid/out_ready   downstream handshake
//   out_data              head entry (the main register)
//   stall_clr             synchronous clear of stall_cnt (wins over increment)
//   stall_cnt             saturating stall cycle count
// Optional: define HOLD_SLICE_ASSERT_EN to compile in interface assertions.
module hold_slice #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             stall_clr,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             in_fire, out_fire, stall;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (state_q != TWO);
  assign out_data  = main_q;
  assign stall_cnt = stall_q;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign stall    = out_valid && !out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = ONE;
          main_d  = in_data;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire) begin
          // Head is still waiting downstream; park the newer beat in skid.
          state_d = TWO;
          skid_d  = in_data;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        // in_ready is low here, so only the drain case exists.
        if (out_fire) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    if (stall_clr)
      stall_d = '0;
    else if (stall && (stall_q != '1))
      stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end

`ifdef HOLD_SLICE_ASSERT_EN
  a_out_hold: assert property (@(posedge clk) disable iff (!rst_n)
      out_valid && !out_ready |=> $stable(out_data) && out_valid)
    $info("%0t hold_slice: output held during stall", $time);
  else
    $error("%0t hold_slice: out_data/out_valid changed during stall", $time);

  a_ready_drop: assert property (@(posedge clk) disable iff (!rst_n)
      !in_ready |=> !out_ready || out_valid)
    $info("%0t hold_slice: ready drop consistent", $time);
  else
    $error("%0t hold_slice: in_ready low without pending output", $time);

  a_up_stable: assert property (@(posedge clk) disable iff (!rst_n)
      in_valid && !in_ready |=> $stable(in_data))
    $info("%0t hold_slice: upstream data held", $time);
  else
    $error("%0t hold_slice: upstream changed in_data while blocked", $time);
`endif

endmodule
